// File: rtl/uarc_pkg.sv
// Shared UARC types: arbiter request encoding and the receive FIFO entry.
// Entry data is sized for the widest supported word (WORD_MAG up to 6); narrower lanes zero-extend.
package uarc_pkg;

   localparam int UARC_DATA_MAX = 64;

   typedef enum logic [2:0] {
      REQ_NONE,
      REQ_KILL,
      REQ_INCEPT,
      REQ_SEND,
      REQ_STREAM
   } uarc_req_e;

   typedef struct packed {
      logic                     is_send;
      logic [UARC_DATA_MAX-1:0] data;
   } uarc_rx_entry_t;

endpackage

// File: rtl/uarc_rx_fifo.sv
// Synchronous FIFO of receive entries; flush wins over push and pop.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module uarc_rx_fifo
   import uarc_pkg::*;
#(
   parameter int FIFO_MAG = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                push,
   input  uarc_rx_entry_t      push_entry,
   input  logic                pop,
   output uarc_rx_entry_t      head,
   output logic                full,
   output logic                empty,
   output logic [FIFO_MAG:0]   count
);

   localparam int DEPTH = 1 << FIFO_MAG;
   localparam logic [FIFO_MAG:0] DEPTH_CNT = (FIFO_MAG + 1)'(DEPTH);

   uarc_rx_entry_t      mem [DEPTH];
   logic [FIFO_MAG-1:0] wr_ptr;
   logic [FIFO_MAG-1:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero before the first push.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uarc_rx_endpoint.sv
// Receiving endpoint of one UARC lane: arbitration, registered acks, incept context, word FIFO.
// Define UARC_RX_PERM_CHECK_EN to drop send/stream words whose sender permissions exceed the incept context.
module uarc_rx_endpoint
   import uarc_pkg::*;
#(
   parameter  int WORD_MAG   = 5,
   parameter  int FIFO_MAG   = 3,
   localparam int WORD_WIDTH = 1 << WORD_MAG
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  kill,
   input  logic                  incept,
   input  logic                  send,
   input  logic                  stream,
   input  logic [WORD_WIDTH-1:0] data,
   input  logic [WORD_WIDTH-1:0] self_permission,
   input  logic [WORD_WIDTH-1:0] self_address,
   input  logic [WORD_WIDTH-1:0] incept_permission,
   input  logic [WORD_WIDTH-1:0] incept_address,
   output logic                  kill_ack,
   output logic                  incept_ack,
   output logic                  send_ack,
   output logic                  stream_ack,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_is_send,
   output logic                  incepted,
   output logic [WORD_WIDTH-1:0] ctx_permission,
   output logic [WORD_WIDTH-1:0] ctx_address,
   output logic [WORD_WIDTH-1:0] ctx_self_permission,
   output logic [WORD_WIDTH-1:0] ctx_self_address,
   output logic                  drop
);

   uarc_req_e           req_sel;
   uarc_rx_entry_t      push_entry;
   uarc_rx_entry_t      head;
   logic                eligible;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [FIFO_MAG:0]   fifo_count;
   logic                word_req;
   logic                perm_block;
   logic                push;
   logic                unused_bits;

   // Any ack in the previous cycle blocks this one, giving one accepted request per two cycles.
   assign eligible = enable && !(kill_ack || incept_ack || send_ack || stream_ack);
   assign pop      = out_valid && out_ready;

   always_comb begin
      req_sel = REQ_NONE;
      if (eligible) begin
         if (kill) begin
            req_sel = REQ_KILL;
         end else if (incept) begin
            req_sel = REQ_INCEPT;
         end else if (send && (!fifo_full || pop)) begin
            req_sel = REQ_SEND;
         end else if (stream && (!fifo_full || pop)) begin
            req_sel = REQ_STREAM;
         end
      end
   end

   assign word_req = (req_sel == REQ_SEND) || (req_sel == REQ_STREAM);
   assign push     = word_req && !perm_block;

   always_comb begin
      push_entry         = '0;
      push_entry.is_send = (req_sel == REQ_SEND);
      push_entry.data    = UARC_DATA_MAX'(data);
   end

`ifdef UARC_RX_PERM_CHECK_EN
   assign perm_block = incepted && ((self_permission & ~ctx_permission) != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         drop <= 1'b0;
      end else begin
         drop <= word_req && perm_block;
      end
   end
`else
   assign perm_block = 1'b0;
   assign drop       = 1'b0;
`endif

   // Acks and context share the accepting edge, so the ack cycle already shows the new state.
   always_ff @(posedge clk) begin
      if (reset) begin
         kill_ack            <= 1'b0;
         incept_ack          <= 1'b0;
         send_ack            <= 1'b0;
         stream_ack          <= 1'b0;
         incepted            <= 1'b0;
         ctx_permission      <= '0;
         ctx_address         <= '0;
         ctx_self_permission <= '0;
         ctx_self_address    <= '0;
      end else begin
         kill_ack   <= (req_sel == REQ_KILL);
         incept_ack <= (req_sel == REQ_INCEPT);
         send_ack   <= (req_sel == REQ_SEND);
         stream_ack <= (req_sel == REQ_STREAM);
         if (req_sel == REQ_KILL) begin
            incepted            <= 1'b0;
            ctx_permission      <= '0;
            ctx_address         <= '0;
            ctx_self_permission <= '0;
            ctx_self_address    <= '0;
         end else if (req_sel == REQ_INCEPT) begin
            incepted            <= 1'b1;
            ctx_permission      <= incept_permission;
            ctx_address         <= incept_address;
            ctx_self_permission <= self_permission;
            ctx_self_address    <= self_address;
         end
      end
   end

   uarc_rx_fifo #(
      .FIFO_MAG (FIFO_MAG)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (req_sel == REQ_KILL),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   assign out_valid   = (fifo_count != '0);
   assign out_data    = head.data[WORD_WIDTH-1:0];
   assign out_is_send = head.is_send;
   assign unused_bits = ^{head.data, fifo_empty};

endmodule

// File: tb/tb_uarc_rx_endpoint.sv
// Directed self-checking bench for uarc_rx_endpoint with a word scoreboard.
// Honours UARC_RX_PERM_CHECK_EN when the design is built with it.
module tb_uarc_rx_endpoint;

   localparam int WORD_MAG   = 5;
   localparam int FIFO_MAG   = 2;
   localparam int WORD_WIDTH = 1 << WORD_MAG;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  enable;
   logic                  kill, incept, send, stream;
   logic [WORD_WIDTH-1:0] data, self_permission, self_address;
   logic [WORD_WIDTH-1:0] incept_permission, incept_address;
   logic                  kill_ack, incept_ack, send_ack, stream_ack;
   logic                  out_valid, out_ready, out_is_send;
   logic [WORD_WIDTH-1:0] out_data;
   logic                  incepted, drop;
   logic [WORD_WIDTH-1:0] ctx_permission, ctx_address;
   logic [WORD_WIDTH-1:0] ctx_self_permission, ctx_self_address;

   int n_checks = 0;
   int n_pass   = 0;
   logic [WORD_WIDTH:0] sb [$];
   logic                exp_drop;

   always #5 clk = ~clk;

   uarc_rx_endpoint #(
      .WORD_MAG (WORD_MAG),
      .FIFO_MAG (FIFO_MAG)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .enable              (enable),
      .kill                (kill),
      .incept              (incept),
      .send                (send),
      .stream              (stream),
      .data                (data),
      .self_permission     (self_permission),
      .self_address        (self_address),
      .incept_permission   (incept_permission),
      .incept_address      (incept_address),
      .kill_ack            (kill_ack),
      .incept_ack          (incept_ack),
      .send_ack            (send_ack),
      .stream_ack          (stream_ack),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_is_send         (out_is_send),
      .incepted            (incepted),
      .ctx_permission      (ctx_permission),
      .ctx_address         (ctx_address),
      .ctx_self_permission (ctx_self_permission),
      .ctx_self_address    (ctx_self_address),
      .drop                (drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_acks(input string tag, input logic [3:0] exp);
      check_output(tag, {kill_ack, incept_ack, send_ack, stream_ack}, exp);
   endtask

   // Drive one request line with payload; the caller ticks.
   task automatic apply_stimulus(input logic k, input logic i, input logic s, input logic st,
                                 input logic [WORD_WIDTH-1:0] d);
      kill   = k;
      incept = i;
      send   = s;
      stream = st;
      data   = d;
   endtask

   // Compare the FIFO head against the scoreboard, then pop it.
   task automatic expect_pop(input string tag);
      logic [WORD_WIDTH:0] e;
      e = (sb.size() == 0) ? '0 : sb.pop_front();
      check_output({tag, "_valid"}, out_valid, 1'b1);
      check_output({tag, "_data"}, out_data, e[WORD_WIDTH-1:0]);
      check_output({tag, "_is_send"}, out_is_send, e[WORD_WIDTH]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      out_ready = 1'b0;
      self_permission = '0;
      self_address = '0;
      incept_permission = '0;
      incept_address = '0;
      apply_stimulus(0, 0, 0, 0, '0);
      tick();
      tick();
      reset = 1'b0;

      check_acks("rst_acks", 4'b0000);
      check_output("rst_valid", out_valid, 1'b0);
      check_output("rst_data", out_data, '0);
      check_output("rst_is_send", out_is_send, 1'b0);
      check_output("rst_incepted", incepted, 1'b0);
      check_output("rst_ctx", {ctx_permission, ctx_address}, '0);
      check_output("rst_ctx_self", {ctx_self_permission, ctx_self_address}, '0);
      check_output("rst_drop", drop, 1'b0);

      // Single stream word, one-cycle ack, visible on the ack edge.
      enable = 1'b1;
      apply_stimulus(0, 0, 0, 1, 32'h11);
      sb.push_back({1'b0, 32'h11});
      tick();
      check_acks("stream_ack", 4'b0001);
      check_output("stream_visible", out_valid, 1'b1);
      apply_stimulus(0, 0, 0, 0, '0);
      tick();
      check_acks("stream_ack_one_cycle", 4'b0000);
      expect_pop("pop_11");
      check_output("empty_after_11", out_valid, 1'b0);

      // Simultaneous kill+incept+send: priority, then blocked cycles between acks.
      self_permission = 32'h30;
      self_address = 32'h55;
      incept_permission = 32'hF0;
      incept_address = 32'h1234;
      apply_stimulus(1, 1, 1, 0, 32'h33);
      tick();
      check_acks("prio_kill", 4'b1000);
      kill = 1'b0;
      tick();
      check_acks("prio_block1", 4'b0000);
      tick();
      check_acks("prio_incept", 4'b0100);
      check_output("incepted_set", incepted, 1'b1);
      check_output("ctx_perm", ctx_permission, 32'hF0);
      check_output("ctx_addr", ctx_address, 32'h1234);
      check_output("ctx_self_perm", ctx_self_permission, 32'h30);
      check_output("ctx_self_addr", ctx_self_address, 32'h55);
      incept = 1'b0;
      sb.push_back({1'b1, 32'h33});
      tick();
      check_acks("prio_block2", 4'b0000);
      tick();
      check_acks("prio_send", 4'b0010);
      send = 1'b0;
      tick();
      check_acks("prio_block3", 4'b0000);
      expect_pop("pop_33");

      // Kill while a word is queued and the consumer is popping.
      apply_stimulus(0, 0, 0, 1, 32'h44);
      tick();
      check_acks("stream_44", 4'b0001);
      stream = 1'b0;
      tick();
      check_output("queued_44", out_valid, 1'b1);
      kill = 1'b1;
      out_ready = 1'b1;
      tick();
      check_acks("kill_ack", 4'b1000);
      check_output("kill_empty", out_valid, 1'b0);
      check_output("kill_incepted", incepted, 1'b0);
      check_output("kill_ctx", {ctx_permission, ctx_address}, '0);
      check_output("kill_ctx_self", {ctx_self_permission, ctx_self_address}, '0);
      kill = 1'b0;
      out_ready = 1'b0;
      tick();

      // Fill the depth-4 FIFO, hold the fifth until a pop frees a slot.
      for (int i = 1; i <= 4; i++) begin
         apply_stimulus(0, 0, 0, 1, WORD_WIDTH'(i));
         sb.push_back({1'b0, WORD_WIDTH'(i)});
         tick();
         check_acks($sformatf("fill_ack_%0d", i), 4'b0001);
         stream = 1'b0;
         tick();
      end
      apply_stimulus(0, 0, 0, 1, 32'h5);
      sb.push_back({1'b0, 32'h5});
      tick();
      check_acks("full_hold1", 4'b0000);
      tick();
      check_acks("full_hold2", 4'b0000);
      expect_pop("pop_1_with_push");
      check_acks("full_push_pop", 4'b0001);
      stream = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         expect_pop($sformatf("drain_%0d", i));
      end
      check_output("drained", out_valid, 1'b0);

      // Permission check against an incept context of 0xF0.
      incept_permission = 32'hF0;
      incept_address = 32'h1234;
      apply_stimulus(0, 1, 0, 0, '0);
      tick();
      check_acks("incept2_ack", 4'b0100);
      incept = 1'b0;
      tick();
      self_permission = 32'h0F;
      apply_stimulus(0, 0, 1, 0, 32'h66);
`ifdef UARC_RX_PERM_CHECK_EN
      exp_drop = 1'b1;
`else
      exp_drop = 1'b0;
      sb.push_back({1'b1, 32'h66});
`endif
      tick();
      check_acks("perm_bad_ack", 4'b0010);
      check_output("perm_bad_drop", drop, exp_drop);
      send = 1'b0;
      tick();
      check_output("perm_drop_pulse", drop, 1'b0);
      self_permission = 32'h30;
      apply_stimulus(0, 0, 1, 0, 32'h77);
      sb.push_back({1'b1, 32'h77});
      tick();
      check_acks("perm_ok_ack", 4'b0010);
      check_output("perm_ok_drop", drop, 1'b0);
      send = 1'b0;
      tick();
      for (int k = 0; k < 4 && sb.size() != 0; k++) begin
         expect_pop($sformatf("perm_pop_%0d", k));
      end
      check_output("perm_drained", out_valid, 1'b0);

      // Requests with the lane deselected are ignored.
      enable = 1'b0;
      apply_stimulus(0, 0, 0, 1, 32'h99);
      tick();
      tick();
      check_acks("disabled_ack", 4'b0000);
      check_output("disabled_valid", out_valid, 1'b0);
      stream = 1'b0;
      enable = 1'b1;
      tick();

      // Reset in the ack cycle of a send with two words queued.
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(0, 0, 1, 0, WORD_WIDTH'(32'hA1 + i));
         tick();
         send = 1'b0;
         tick();
      end
      check_output("two_queued", out_valid, 1'b1);
      apply_stimulus(0, 0, 1, 0, 32'hA3);
      tick();
      check_acks("pre_reset_ack", 4'b0010);
      reset = 1'b1;
      tick();
      check_acks("reset_acks", 4'b0000);
      check_output("reset_valid", out_valid, 1'b0);
      check_output("reset_data", out_data, '0);
      check_output("reset_is_send", out_is_send, 1'b0);
      check_output("reset_incepted", incepted, 1'b0);
      check_output("reset_ctx", {ctx_permission, ctx_self_permission}, '0);
      check_output("reset_drop", drop, 1'b0);
      reset = 1'b0;
      sb.delete();
      sb.push_back({1'b1, 32'hA3});
      tick();
      check_acks("post_reset_ack", 4'b0010);
      send = 1'b0;
      tick();
      expect_pop("pop_a3");
      check_output("final_empty", out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
